// File: rtl/sp_pkg.sv
// Shared widths and type definitions for simple_processor blocks.
package sp_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_e;

endpackage

// File: rtl/sp_mem_arbiter_rr.sv
// Combinational two-way round-robin picker: req[0] is the instruction port,
// req[1] the data port; on a tie the port that did not win last time wins.
module sp_rr_arb2
  import sp_pkg::*;
(
  input  logic [1:0] req,
  input  arb_port_e  last,
  output logic [1:0] gnt,
  output arb_port_e  winner
);

  always_comb begin
    gnt    = '0;
    winner = PORT_I;
    if (req == 2'b11) begin
      winner = (last == PORT_I) ? PORT_D : PORT_I;
      gnt    = (last == PORT_I) ? 2'b10 : 2'b01;
    end else if (req[1]) begin
      winner = PORT_D;
      gnt    = 2'b10;
    end else if (req[0]) begin
      winner = PORT_I;
      gnt    = 2'b01;
    end
  end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Shares one memory port between the instruction and data ports of
// simple_processor; one transaction in flight, every output registered.
module sp_mem_arbiter
  import sp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = sp_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = sp_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  imem_req_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  output logic                  imem_ack_o,
  input  logic                  dmem_req_i,
  input  logic                  dmem_wr_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);

  arb_state_e            state_q;
  arb_port_e             owner_q;
  arb_port_e             last_q;
  arb_port_e             winner;
  logic [1:0]            gnt;
  logic [DATA_WIDTH-1:0] rdata_q;

  sp_rr_arb2 u_rr (
    .req    ({dmem_req_i, imem_req_i}),
    .last   (last_q),
    .gnt    (gnt),
    .winner (winner)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      owner_q     <= PORT_I;
      last_q      <= PORT_D;
      mem_req_o   <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_q     <= '0;
      imem_ack_o  <= 1'b0;
      dmem_ack_o  <= 1'b0;
    end else begin
      imem_ack_o <= 1'b0;
      dmem_ack_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            state_q   <= BUSY;
            owner_q   <= winner;
            last_q    <= winner;
            mem_req_o <= 1'b1;
            if (gnt[1]) begin
              mem_wr_o    <= dmem_wr_i;
              mem_addr_o  <= dmem_addr_i;
              mem_wdata_o <= dmem_wdata_i;
            end else begin
              mem_wr_o    <= 1'b0;
              mem_addr_o  <= imem_addr_i;
              mem_wdata_o <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state_q    <= RESP;
            mem_req_o  <= 1'b0;
            // Writes leave the last read data visible on both rdata outputs.
            if (!mem_wr_o) rdata_q <= mem_rdata_i;
            imem_ack_o <= (owner_q == PORT_I);
            dmem_ack_o <= (owner_q == PORT_D);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_rdata_o = rdata_q;
  assign dmem_rdata_o = rdata_q;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed bench for sp_mem_arbiter: inputs driven and outputs sampled on the
// falling clock edge, expected values written out by hand for each step.
module tb_sp_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        imem_req_i = 1'b0;
  logic [31:0] imem_addr_i = '0;
  logic [31:0] imem_rdata_o;
  logic        imem_ack_o;
  logic        dmem_req_i = 1'b0;
  logic        dmem_wr_i = 1'b0;
  logic [31:0] dmem_addr_i = '0;
  logic [31:0] dmem_wdata_i = '0;
  logic [31:0] dmem_rdata_o;
  logic        dmem_ack_o;
  logic        mem_req_o;
  logic        mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  sp_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .imem_req_i   (imem_req_i),
    .imem_addr_i  (imem_addr_i),
    .imem_rdata_o (imem_rdata_o),
    .imem_ack_o   (imem_ack_o),
    .dmem_req_i   (dmem_req_i),
    .dmem_wr_i    (dmem_wr_i),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_rdata_o (dmem_rdata_o),
    .dmem_ack_o   (dmem_ack_o),
    .mem_req_o    (mem_req_o),
    .mem_wr_o     (mem_wr_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [31:0] exp_rdata);
    chk({tag, "_imem_ack"}, imem_ack_o, 0);
    chk({tag, "_dmem_ack"}, dmem_ack_o, 0);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_irdata"}, imem_rdata_o, exp_rdata);
    chk({tag, "_drdata"}, dmem_rdata_o, exp_rdata);
  endtask

  // Entered at the falling edge of the cycle in which the request is presented
  // while the arbiter is idle; mem_req_o is expected in the very next cycle.
  task automatic txn(input string tag, input bit exp_d, input logic [31:0] exp_addr,
                     input bit exp_wr, input logic [31:0] exp_wdata,
                     input logic [31:0] mem_data, input logic [31:0] exp_rdata,
                     input int lat, input bit drop);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!mem_req_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_req_wait"}, n, 0);
    chk({tag, "_mem_req"}, mem_req_o, 1);
    chk({tag, "_mem_addr"}, mem_addr_o, exp_addr);
    chk({tag, "_mem_wr"}, mem_wr_o, exp_wr);
    chk({tag, "_mem_wdata"}, mem_wdata_o, exp_wdata);
    chk({tag, "_busy_iack"}, imem_ack_o, 0);
    chk({tag, "_busy_dack"}, dmem_ack_o, 0);
    repeat (lat) @(negedge clk_i);
    chk({tag, "_held_addr"}, mem_addr_o, exp_addr);
    mem_ack_i   = 1'b1;
    mem_rdata_i = mem_data;
    @(negedge clk_i);
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hBAD0_BAD0;
    chk({tag, "_imem_ack"}, imem_ack_o, !exp_d);
    chk({tag, "_dmem_ack"}, dmem_ack_o, exp_d);
    chk({tag, "_req_drop"}, mem_req_o, 0);
    chk({tag, "_rdata"}, exp_d ? dmem_rdata_o : imem_rdata_o, exp_rdata);
    if (drop) begin
      if (exp_d) dmem_req_i = 1'b0;
      else       imem_req_i = 1'b0;
    end
    @(negedge clk_i);
    chk({tag, "_ack_end_i"}, imem_ack_o, 0);
    chk({tag, "_ack_end_d"}, dmem_ack_o, 0);
  endtask

  initial begin
    // Reset state
    @(negedge clk_i);
    chk("rst_mem_wr", mem_wr_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk_idle_outputs("rst", 32'h0);
    arst_i = 1'b0;
    @(negedge clk_i);

    // Lone instruction read, memory answers two cycles into BUSY
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h10;
    txn("iread", 1'b0, 32'h10, 1'b0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1'b1);
    chk("iread_dmem_rdata", dmem_rdata_o, 32'hDEADBEEF);

    // Data write keeps the previous read data
    dmem_req_i   = 1'b1;
    dmem_wr_i    = 1'b1;
    dmem_addr_i  = 32'h20;
    dmem_wdata_i = 32'h1234;
    txn("dwrite", 1'b1, 32'h20, 1'b1, 32'h1234, 32'hCAFEF00D, 32'hDEADBEEF, 1, 1'b1);
    chk_idle_outputs("dwrite_after", 32'hDEADBEEF);

    // Reset in BUSY drops the transaction asynchronously
    dmem_wr_i   = 1'b0;
    dmem_addr_i = 32'h30;
    dmem_req_i  = 1'b1;
    @(negedge clk_i);
    chk("mid_busy_req", mem_req_o, 1);
    chk("mid_busy_addr", mem_addr_o, 32'h30);
    #2 arst_i = 1'b1;
    #1;
    chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_wdata", mem_wdata_o, 0);
    chk_idle_outputs("mid_rst", 32'h0);
    dmem_req_i = 1'b0;
    @(negedge clk_i);
    arst_i    = 1'b0;
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    chk_idle_outputs("late_ack", 32'h0);
    @(negedge clk_i);
    chk_idle_outputs("late_ack2", 32'h0);

    // Simultaneous requests after reset: I first, then strict alternation
    imem_req_i   = 1'b1;
    imem_addr_i  = 32'h80;
    dmem_req_i   = 1'b1;
    dmem_wr_i    = 1'b0;
    dmem_addr_i  = 32'h40;
    dmem_wdata_i = 32'h5555;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      bit          is_d;
      is_d = (i % 2) == 1;
      d    = is_d ? (32'h2000 + i) : (32'h1000 + i);
      txn($sformatf("alt%0d", i), is_d, is_d ? 32'h40 : 32'h80, 1'b0,
          is_d ? 32'h5555 : 32'h0, d, d, i % 3, i >= 6);
    end

    // Minimum latency, then a spurious downstream ack while idle
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h44;
    txn("minlat", 1'b0, 32'h44, 1'b0, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 1'b1);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h7777_7777;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    chk_idle_outputs("spurious", 32'h0BAD_F00D);
    @(negedge clk_i);
    chk_idle_outputs("spurious2", 32'h0BAD_F00D);

    // Arbiter still healthy: lone data read
    dmem_req_i  = 1'b1;
    dmem_addr_i = 32'h48;
    txn("dread", 1'b1, 32'h48, 1'b0, 32'h5555, 32'h1357_9BDF, 32'h1357_9BDF, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sp_mem_arbiter.md
# sp_mem_arbiter

Two-port to one-port memory arbiter for `simple_processor`. It shares a single unified memory port between the processor's instruction fetch port (`imem_*`, read-only) and data port (`dmem_*`, read/write). It is placed between the core and the memory model or bus bridge. Simultaneous requests are resolved round-robin, one transaction is outstanding at a time, and all downstream outputs are registered.

## Interface
- `ADDR_WIDTH`, default `sp_pkg::ADDR_WIDTH`: width of all address buses.
- `DATA_WIDTH`, default `sp_pkg::DATA_WIDTH`: width of all data buses.

Ports:
- `clk_i` input 1: single global clock; all state updates on the rising edge.
- `arst_i` input 1: asynchronous, active-high reset.
- `imem_req_i` input 1: instruction read request; held until `imem_ack_o`.
- `imem_addr_i` input ADDR_WIDTH: instruction address; stable while `imem_req_i` is high.
- `imem_rdata_o` output DATA_WIDTH: instruction read data; valid when `imem_ack_o` is high.
- `imem_ack_o` output 1: one-cycle completion pulse to the instruction port.
- `dmem_req_i` input 1: data request; held until `dmem_ack_o`.
- `dmem_wr_i` input 1: 1 means write, 0 means read.
- `dmem_addr_i` input ADDR_WIDTH: data address.
- `dmem_wdata_i` input DATA_WIDTH: write data.
- `dmem_rdata_o` output DATA_WIDTH: data read data; valid when `dmem_ack_o` is high and the request was a read.
- `dmem_ack_o` output 1: one-cycle completion pulse to the data port.
- `mem_req_o` output 1: downstream request; held until `mem_ack_i`.
- `mem_wr_o` output 1: downstream write enable.
- `mem_addr_o` output ADDR_WIDTH: downstream address.
- `mem_wdata_o` output DATA_WIDTH: downstream write data.
- `mem_rdata_i` input DATA_WIDTH: downstream read data; valid with `mem_ack_i`.
- `mem_ack_i` input 1: downstream one-cycle completion pulse.

## Operation
- **States:** IDLE, BUSY, RESP. The owner register records I or D. The last-grant register (`last_q`) records I or D.
- **IDLE:**
  - If any request is high, the arbiter picks a winner and latches `mem_addr_o`, `mem_wr_o` and `mem_wdata_o` from the winner's inputs.
  - For the instruction port, `mem_wr_o`=0 and `mem_wdata_o`=0.
  - It then sets owner, updates `last_q` to the winner and moves to BUSY.
- **Winner selection:** a single request wins. When both ports request, the port that is not `last_q` wins.
- **BUSY:**
  - `mem_req_o`=1 and the downstream outputs are held stable.
  - On `mem_ack_i`, the arbiter captures `mem_rdata_i` into `rdata_q` and moves to RESP.
  - On a write, `rdata_q` is left unchanged.
- **RESP:**
  - The owner's ack is high for exactly one cycle and the arbiter returns to IDLE.
  - The other port's ack stays 0.
- **Read data:** `imem_rdata_o` and `dmem_rdata_o` are both driven from `rdata_q`.
- **Ignored events:**
  - `mem_ack_i` in IDLE or RESP is ignored.
  - A change of `*_req_i` while in BUSY or RESP has no effect on the current transaction.
- **Requester rule:** a requester deasserts its request, or presents a new one, in the cycle after its ack. A request still high in IDLE is treated as a new request.
- **Reset:**
  - While `arst_i` is high, all outputs are 0, `rdata_q`=0, state is IDLE and `last_q`=D, so I wins the first tie.
  - A reset in BUSY or RESP drops the transaction immediately. No ack is issued, and a late `mem_ack_i` is ignored.

## Timing
- **Request to downstream:** a request sampled in IDLE at edge N gives `mem_req_o`=1 from cycle N+1.
- **Downstream ack to requester ack:** `mem_ack_i` sampled at edge M gives `mem_req_o`=0 and the requester ack =1 in cycle M+1. The requester ack returns to 0 in cycle M+2.
- **Minimum latency:** 3 cycles from request to ack, when memory acks in the first BUSY cycle.
- **Throughput:** at most one transaction per 3 cycles plus memory latency.
- **Alternation:** two ports requesting back-to-back alternate strictly I, D, I, D.
- **Registered outputs:** all outputs are registered, with no combinational path from any input to any output.

## Structure
- **`sp_pkg`:**
  - Existing `ADDR_WIDTH` and `DATA_WIDTH`.
  - New `arb_state_e` enum {IDLE, BUSY, RESP}.
  - New `arb_port_e` enum {PORT_I, PORT_D}.
- **Sub-module `sp_rr_arb2`:** a combinational two-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `gnt[1:0]` (one-hot or zero) and the winner.
- **Top level:** holds the FSM, the latched downstream registers and `rdata_q`.

## Test plan
- **Reset mid-transaction:** assert `arst_i` while in BUSY → all outputs go to 0 asynchronously. A `mem_ack_i` pulse afterwards produces no ack, and the next request starts cleanly.
- **Lone instruction read:** `imem_req_i`=1, addr 0x10; memory acks 2 cycles after `mem_req_o`=1 with 0xDEADBEEF → `mem_wr_o`=0 and `mem_addr_o`=0x10. `imem_ack_o` pulses once with `imem_rdata_o`=0xDEADBEEF, and `dmem_ack_o` stays 0.
- **Data write:** `dmem_req_i`=1, `dmem_wr_i`=1, addr 0x20, wdata 0x1234 → `mem_wr_o`=1, `mem_addr_o`=0x20, `mem_wdata_o`=0x1234. `dmem_ack_o` pulses once, and `rdata_q` is unchanged from the previous read.
- **Simultaneous first requests:** both ports request in the same cycle right after reset → I is granted first, then D. Continuous requests from both ports alternate I, D, I, D over 8 transactions.
- **Minimum latency:** memory acks in the first BUSY cycle → the requester ack arrives exactly 3 cycles after the request. `mem_req_o` is low in the ack cycle, and a spurious `mem_ack_i` in IDLE is ignored.
